// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StBurst
    } arb_state_e;

    localparam int unsigned DefNumReq    = 4;
    localparam int unsigned DefDataWidth = 8;
    localparam int unsigned DefBurstLen  = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping at NUM_REQ.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    localparam logic [IDX_W:0] NumReqW = (IDX_W + 1)'(NUM_REQ);

    logic [IDX_W:0] sum;

    // Walk offsets 0..NUM_REQ-1 from ptr; the extra bit holds ptr+offset before the wrap.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        sum   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr} + (IDX_W + 1)'(i);
            if (sum >= NumReqW) begin
                sum = sum - NumReqW;
            end
            if (!found && req[IDX_W'(sum)]) begin
                found = 1'b1;
                idx   = IDX_W'(sum);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter merging NUM_REQ write requesters into one FIFO write port.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DefNumReq,
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned BURST_LEN  = DefBurstLen
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int unsigned IdxW  = $clog2(NUM_REQ);
    localparam int unsigned BeatW = $clog2(BURST_LEN + 1);

    localparam logic [BeatW-1:0] LastBeat = BeatW'(BURST_LEN - 1);
    localparam logic [IdxW-1:0]  LastIdx  = IdxW'(NUM_REQ - 1);

    arb_state_e       state_q, state_d;
    logic [IdxW-1:0]  owner_q, owner_d;
    logic [BeatW-1:0] beat_cnt_q, beat_cnt_d;
    logic [IdxW-1:0]  rr_ptr_q, rr_ptr_d;

    logic             pick_found;
    logic [IdxW-1:0]  pick_idx;
    logic             owner_valid;
    logic             burst_exit;
    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IdxW)
    ) u_rr_pick (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign owner_valid = req_valid[owner_q];

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        beat_cnt_d   = beat_cnt_q;
        rr_ptr_d     = rr_ptr_q;
        req_ready    = '0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = '0;
        burst_exit   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!fifo_full && pick_found) begin
                    state_d    = StBurst;
                    owner_d    = pick_idx;
                    beat_cnt_d = '0;
                end
            end
            StBurst: begin
                req_ready[owner_q] = !fifo_full;
                fifo_wr_en         = owner_valid && !fifo_full;
                fifo_wr_data       = data_arr[owner_q];
                // A full stall neither counts a beat nor ends the burst.
                if (!owner_valid) begin
                    burst_exit = 1'b1;
                end else if (fifo_wr_en) begin
                    if (beat_cnt_q == LastBeat) begin
                        burst_exit = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BeatW'(1);
                    end
                end
                if (burst_exit) begin
                    state_d  = StIdle;
                    rr_ptr_d = (owner_q == LastIdx) ? '0 : owner_q + IdxW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            owner_q    <= '0;
            beat_cnt_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign grant_id = owner_q;
    assign busy     = (state_q == StBurst);

endmodule
